// File: rtl/wish_unpack_keep_pkg.sv
// Shared definitions for the Wishbone-style word unpacker: tag bit positions and FSM encoding.
package wish_unpack_keep_pkg;

  localparam int unsigned TGC_FIRST = 0;
  localparam int unsigned TGC_LAST  = 1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } state_t;

endpackage

// File: rtl/wish_unpack_keep_sel.sv
// Combinational sub-word selector: picks slice idx of a packed word, MSB-first or LSB-first.
module wish_unpack_keep_sel #(
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned NUM_PACK      = 4,
  parameter int unsigned LITTLE_ENDIAN = 0,
  parameter int unsigned IDX_WIDTH     = 2
) (
  input  logic [DATA_WIDTH*NUM_PACK-1:0] word,
  input  logic [IDX_WIDTH-1:0]           idx,
  output logic [DATA_WIDTH-1:0]          dat_c
);

  always_comb begin
    dat_c = '0;
    for (int unsigned k = 0; k < NUM_PACK; k++) begin
      if (idx == IDX_WIDTH'(k)) begin
        if (LITTLE_ENDIAN != 0) dat_c = word[k*DATA_WIDTH +: DATA_WIDTH];
        else                    dat_c = word[(NUM_PACK-k)*DATA_WIDTH-1 -: DATA_WIDTH];
      end
    end
  end

endmodule

// File: rtl/wish_unpack_keep.sv
// Unpacks one wide word into up to NUM_PACK sub-words with first/last tagging.
// Optional WISH_UNPACK_KEEP_ERR_EN: drop words with illegal count and raise sticky err_o.
module wish_unpack_keep
  import wish_unpack_keep_pkg::*;
#(
  parameter int unsigned DATA_WIDTH    = 8,
  parameter int unsigned NUM_PACK      = 4,
  parameter int unsigned TGC_WIDTH     = 2,
  parameter int unsigned LITTLE_ENDIAN = 0
) (
  input  logic                             clk_i,
  input  logic                             rst_n_i,
  input  logic                             s_stb_i,
  input  logic                             s_cyc_i,
  input  logic [DATA_WIDTH*NUM_PACK-1:0]   s_dat_i,
  input  logic [$clog2(NUM_PACK+1)-1:0]    s_cnt_i,
  input  logic [TGC_WIDTH-1:0]             s_tgc_i,
  output logic                             s_ack_o,
  output logic                             s_stall_o,
  output logic                             d_stb_o,
  output logic                             d_cyc_o,
  output logic [DATA_WIDTH-1:0]            d_dat_o,
  output logic [TGC_WIDTH-1:0]             d_tgc_o,
`ifdef WISH_UNPACK_KEEP_ERR_EN
  output logic                             err_o,
`endif
  input  logic                             d_ack_i
);

  localparam int unsigned PW = DATA_WIDTH * NUM_PACK;
  localparam int unsigned CW = $clog2(NUM_PACK + 1);
  localparam int unsigned IW = $clog2(NUM_PACK);

  state_t          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [PW-1:0]   word_q, word_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [TGC_WIDTH-1:0] tgc_q, tgc_d;

  logic            last_c;
  logic            cnt_bad_c;
  logic [CW-1:0]   cnt_eff_c;
  logic            src_xfer_c;
  logic            snk_xfer_c;
  logic            load_c;
  logic [DATA_WIDTH-1:0] sel_dat_c;

  // Handshake terms; stall releases only on the cycle the final sub-word leaves.
  assign last_c     = (CW'(idx_q) == (cnt_q - CW'(1)));
  assign d_stb_o    = (state_q == ST_EMIT);
  assign d_cyc_o    = d_stb_o;
  assign s_stall_o  = d_stb_o & ~(d_ack_i & last_c);
  assign s_ack_o    = s_stb_i & s_cyc_i & ~s_stall_o;
  assign src_xfer_c = s_ack_o;
  assign snk_xfer_c = d_stb_o & d_ack_i;

  assign cnt_bad_c  = (s_cnt_i == '0) || (s_cnt_i > CW'(NUM_PACK));
  assign cnt_eff_c  = cnt_bad_c ? CW'(NUM_PACK) : s_cnt_i;

`ifdef WISH_UNPACK_KEEP_ERR_EN
  logic err_q, err_d;
  assign load_c = src_xfer_c & ~cnt_bad_c;
  assign err_d  = err_q | (src_xfer_c & cnt_bad_c);
  assign err_o  = err_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) err_q <= 1'b0;
    else          err_q <= err_d;
  end
`else
  assign load_c = src_xfer_c;
`endif

  // Next-state: a load always restarts at sub-word 0, which also covers back-to-back words.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    word_d  = word_q;
    cnt_d   = cnt_q;
    tgc_d   = tgc_q;
    unique case (state_q)
      ST_IDLE: begin
        if (load_c) begin
          state_d = ST_EMIT;
          idx_d   = '0;
          word_d  = s_dat_i;
          cnt_d   = cnt_eff_c;
          tgc_d   = s_tgc_i;
        end
      end
      ST_EMIT: begin
        if (load_c) begin
          state_d = ST_EMIT;
          idx_d   = '0;
          word_d  = s_dat_i;
          cnt_d   = cnt_eff_c;
          tgc_d   = s_tgc_i;
        end else if (snk_xfer_c && last_c) begin
          state_d = ST_IDLE;
          idx_d   = '0;
        end else if (snk_xfer_c) begin
          idx_d   = idx_q + IW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        idx_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      word_q  <= '0;
      cnt_q   <= '0;
      tgc_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      word_q  <= word_d;
      cnt_q   <= cnt_d;
      tgc_q   <= tgc_d;
    end
  end

  wish_unpack_keep_sel #(
    .DATA_WIDTH    (DATA_WIDTH),
    .NUM_PACK      (NUM_PACK),
    .LITTLE_ENDIAN (LITTLE_ENDIAN),
    .IDX_WIDTH     (IW)
  ) u_sel (
    .word  (word_q),
    .idx   (idx_q),
    .dat_c (sel_dat_c)
  );

  assign d_dat_o = d_stb_o ? sel_dat_c : '0;

  // First/last only on the boundary sub-words; user bits ride along on every sub-word.
  always_comb begin
    d_tgc_o = '0;
    if (d_stb_o) begin
      d_tgc_o            = tgc_q;
      d_tgc_o[TGC_FIRST] = tgc_q[TGC_FIRST] & (idx_q == '0);
      d_tgc_o[TGC_LAST]  = tgc_q[TGC_LAST] & last_c;
    end
  end

endmodule

// File: tb/tb_wish_unpack_keep.sv
// Scoreboard bench for wish_unpack_keep (MSB-first and LSB-first instances share stimulus).
module tb_wish_unpack_keep;

  logic        clk;
  logic        rst_n;
  logic        s_stb, s_cyc;
  logic [31:0] s_dat;
  logic [2:0]  s_cnt;
  logic [1:0]  s_tgc;
  logic        s_ack_o, s_stall_o, d_stb_o, d_cyc_o;
  logic [7:0]  d_dat_o;
  logic [1:0]  d_tgc_o;
  logic        le_ack, le_stall, le_stb, le_cyc;
  logic [7:0]  le_dat;
  logic [1:0]  le_tgc;
  logic        d_ack;
  logic        ack_rnd;
  bit          ack_rand;
  logic        ack_force;
`ifdef WISH_UNPACK_KEEP_ERR_EN
  logic        err_o, le_err;
  bit          err_model;
`endif

  typedef struct {
    logic [7:0] be;
    logic [7:0] le;
    logic [1:0] tgc;
    bit         fin;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   pops     = 0;
  int   run      = 0;
  int   last_run = 0;

  wish_unpack_keep #(.DATA_WIDTH(8), .NUM_PACK(4), .TGC_WIDTH(2), .LITTLE_ENDIAN(0)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .s_stb_i(s_stb), .s_cyc_i(s_cyc), .s_dat_i(s_dat),
    .s_cnt_i(s_cnt), .s_tgc_i(s_tgc), .s_ack_o(s_ack_o), .s_stall_o(s_stall_o),
    .d_stb_o(d_stb_o), .d_cyc_o(d_cyc_o), .d_dat_o(d_dat_o), .d_tgc_o(d_tgc_o),
`ifdef WISH_UNPACK_KEEP_ERR_EN
    .err_o(err_o),
`endif
    .d_ack_i(d_ack));

  wish_unpack_keep #(.DATA_WIDTH(8), .NUM_PACK(4), .TGC_WIDTH(2), .LITTLE_ENDIAN(1)) dut_le (
    .clk_i(clk), .rst_n_i(rst_n), .s_stb_i(s_stb), .s_cyc_i(s_cyc), .s_dat_i(s_dat),
    .s_cnt_i(s_cnt), .s_tgc_i(s_tgc), .s_ack_o(le_ack), .s_stall_o(le_stall),
    .d_stb_o(le_stb), .d_cyc_o(le_cyc), .d_dat_o(le_dat), .d_tgc_o(le_tgc),
`ifdef WISH_UNPACK_KEEP_ERR_EN
    .err_o(le_err),
`endif
    .d_ack_i(d_ack));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) ack_rnd = ($urandom_range(0, 3) != 0);
  assign d_ack = ack_rand ? ack_rnd : ack_force;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: expand a word into its sub-word sequence from the slicing rules.
  function automatic void push_word(input logic [31:0] w, input int cnt_raw, input logic [1:0] t);
    int   n;
    exp_t e;
    n = (cnt_raw == 0 || cnt_raw > 4) ? 4 : cnt_raw;
    for (int k = 0; k < n; k++) begin
      e.be  = 8'(w >> ((3 - k) * 8));
      e.le  = 8'(w >> (k * 8));
      e.tgc = {t[1] && (k == n - 1), t[0] && (k == 0)};
      e.fin = (k == n - 1);
      sb.push_back(e);
    end
  endfunction

  // Monitor: samples just before each rising edge and compares against the queue head.
  always begin
    bit exp_stall;
    bit bad;
    @(negedge clk);
    #4;
    if (!rst_n) begin
      sb.delete();
      run = 0;
`ifdef WISH_UNPACK_KEEP_ERR_EN
      err_model = 1'b0;
`endif
    end else begin
      check("d_stb", 32'(d_stb_o), 32'(sb.size() != 0));
      check("d_cyc", 32'(d_cyc_o), 32'(sb.size() != 0));
      check("le_stb", 32'(le_stb), 32'(sb.size() != 0));
      exp_stall = 1'b0;
      if (sb.size() != 0) begin
        cur = sb[0];
        check("d_dat", 32'(d_dat_o), 32'(cur.be));
        check("d_tgc", 32'(d_tgc_o), 32'(cur.tgc));
        check("le_dat", 32'(le_dat), 32'(cur.le));
        exp_stall = !(d_ack && cur.fin);
      end
      check("s_stall", 32'(s_stall_o), 32'(exp_stall));
      check("s_ack", 32'(s_ack_o), 32'(s_stb && s_cyc && !exp_stall));
`ifdef WISH_UNPACK_KEEP_ERR_EN
      check("err_o", 32'(err_o), 32'(err_model));
`endif
      if (d_stb_o) run++;
      else begin
        if (run != 0) last_run = run;
        run = 0;
      end
      if (d_stb_o && d_ack && sb.size() != 0) begin
        void'(sb.pop_front());
        pops++;
      end
      if (s_ack_o) begin
        bad = (s_cnt == 3'd0) || (s_cnt > 3'd4);
`ifdef WISH_UNPACK_KEEP_ERR_EN
        if (bad) err_model = 1'b1;
        else     push_word(s_dat, int'(s_cnt), s_tgc);
`else
        if (bad) push_word(s_dat, 4, s_tgc);
        else     push_word(s_dat, int'(s_cnt), s_tgc);
`endif
      end
    end
  end

  task automatic send(input logic [31:0] w, input int cnt, input logic [1:0] t);
    bit ok;
    ok = 1'b0;
    @(negedge clk);
    s_stb = 1'b1; s_cyc = 1'b1; s_dat = w; s_cnt = 3'(cnt); s_tgc = t;
    for (int i = 0; i < 200 && !ok; i++) begin
      #4;
      if (s_ack_o) ok = 1'b1;
      else @(negedge clk);
    end
    check("send_accept", 32'(ok), 32'd1);
  endtask

  task automatic idle();
    @(negedge clk);
    s_stb = 1'b0; s_cyc = 1'b0;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (sb.size() != 0 && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    check("drain_timeout", 32'(guard < 500), 32'd1);
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_pops(input int target);
    int guard;
    guard = 0;
    while (pops < target && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check("pops_timeout", 32'(guard < 100), 32'd1);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_stb"}, 32'(d_stb_o), 32'd0);
    check({tag, "_cyc"}, 32'(d_cyc_o), 32'd0);
    check({tag, "_dat"}, 32'(d_dat_o), 32'd0);
    check({tag, "_tgc"}, 32'(d_tgc_o), 32'd0);
    check({tag, "_stall"}, 32'(s_stall_o), 32'd0);
`ifdef WISH_UNPACK_KEEP_ERR_EN
    check({tag, "_err"}, 32'(err_o), 32'd0);
`endif
  endtask

  initial begin
    int base;
    int cnt;
    rst_n = 1'b0;
    s_stb = 1'b0; s_cyc = 1'b0; s_dat = '0; s_cnt = '0; s_tgc = '0;
    ack_rand = 1'b0; ack_force = 1'b1;
    #1;
    check_zero("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Full word, first on AA, last on DD.
    send(32'hAABBCCDD, 4, 2'b11);
    idle();
    drain();
    check("run_full", 32'(last_run), 32'd4);

    // Short word then full word: next word accepted on the final sub-word's ack.
    send(32'h11223344, 2, 2'b10);
    send(32'hAABBCCDD, 4, 2'b11);
    idle();
    drain();
    check("run_short_full", 32'(last_run), 32'd6);

    // Two full words back-to-back: eight contiguous strobes.
    send(32'h01020304, 4, 2'b11);
    send(32'hA5B6C7D8, 4, 2'b01);
    idle();
    drain();
    check("run_b2b", 32'(last_run), 32'd8);

    // Sink backpressure on BB for three cycles.
    base = pops;
    send(32'hAABBCCDD, 4, 2'b11);
    idle();
    wait_pops(base + 1);
    ack_force = 1'b0;
    repeat (3) @(negedge clk);
    ack_force = 1'b1;
    drain();
    check("hold_pops", 32'(pops - base), 32'd4);

    // Three sub-words (LSB-first instance yields DD,CC,BB) and single sub-word.
    send(32'hAABBCCDD, 3, 2'b11);
    send(32'h5A000000, 1, 2'b11);
    idle();
    drain();

    // Reset after BB: nothing further, next word restarts at sub-word 0.
    base = pops;
    send(32'hAABBCCDD, 4, 2'b11);
    idle();
    wait_pops(base + 2);
    rst_n = 1'b0;
    #1;
    check_zero("midreset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    base = pops;
    send(32'h55667788, 4, 2'b11);
    idle();
    drain();
    check("post_reset_pops", 32'(pops - base), 32'd4);

`ifdef WISH_UNPACK_KEEP_ERR_EN
    send(32'h12345678, 0, 2'b11);
    idle();
    drain();
    check("err_sticky", 32'(err_o), 32'd1);
    send(32'h9ABCDEF0, 4, 2'b11);
    idle();
    drain();
    check("err_still", 32'(err_o), 32'd1);
`endif

    // Randomized traffic with random sink backpressure and idle gaps.
    ack_rand = 1'b1;
    for (int i = 0; i < 250; i++) begin
      if ($urandom_range(0, 7) == 0) cnt = ($urandom_range(0, 1) != 0) ? 0 : int'($urandom_range(5, 7));
      else cnt = int'($urandom_range(1, 4));
      send($urandom, cnt, 2'($urandom));
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        s_stb = 1'($urandom); s_cyc = 1'b0; s_dat = $urandom;
      end
    end
    idle();
    ack_rand = 1'b0;
    ack_force = 1'b1;
    drain();
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
